// File: rtl/uart_ack_tx.sv
// uart_ack_tx: 8N1 serial transmitter that returns a 6-byte status frame
// {HDR0, HDR1, func_code, status, seq, checksum} for every accepted
// command packet. A one-deep pending buffer absorbs one request that
// arrives while a frame is in flight. Any further request is dropped and
// flagged on the sticky ovf output.
module uart_ack_tx #(
  parameter int         CLK_FREQ = 50000000,
  parameter int         UART_BPS = 115200,
  parameter logic [7:0] HDR0     = 8'h55,
  parameter logic [7:0] HDR1     = 8'hAA
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pack_done,
  input  logic [7:0] func_code,
  input  logic [7:0] status,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ovf
);

  localparam int              BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int              CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Frame checksum: plain modulo-256 sum of the five preceding bytes.
  function automatic logic [7:0] frame_sum(input logic [7:0] fc,
                                           input logic [7:0] st,
                                           input logic [7:0] sq);
    return HDR0 + HDR1 + fc + st + sq;
  endfunction

  state_t           state_r, state_d;
  logic [CNT_W-1:0] cnt_r, cnt_d;
  logic [2:0]       bit_r, bit_d;
  logic [2:0]       byte_r, byte_d;
  logic [7:0]       seq_r, seq_d;
  logic             txd_r, txd_d;
  logic             busy_r, busy_d;
  logic             done_r, done_d;
  logic             pend_r, pend_d;
  logic             ovf_r;

  logic [7:0]       fc_r, st_r, csum_r;
  logic [7:0]       pend_fc_r, pend_st_r;
  logic [7:0]       cur_byte;
  logic [2:0]       bit_nxt;
  logic             bit_end;
  logic             load_new, load_pend;
  logic             to_pend, drop;

  assign bit_end = (cnt_r == CNT_MAX);
  assign bit_nxt = bit_r + 3'd1;

  // A request while the pending slot is full is lost; a request while the
  // shifter is occupied (any state but IDLE, DONE included) is parked.
  assign drop    = pack_done & pend_r;
  assign to_pend = pack_done & ~pend_r & (state_r != IDLE);

  // Select the byte currently being shifted out.
  always_comb begin
    cur_byte = 8'hFF;
    case (byte_r)
      3'd0:    cur_byte = HDR0;
      3'd1:    cur_byte = HDR1;
      3'd2:    cur_byte = fc_r;
      3'd3:    cur_byte = st_r;
      3'd4:    cur_byte = seq_r;
      3'd5:    cur_byte = csum_r;
      default: cur_byte = 8'hFF;
    endcase
  end

  // Next-state logic; serial line, busy and done are registered from here.
  always_comb begin
    state_d   = state_r;
    cnt_d     = cnt_r;
    bit_d     = bit_r;
    byte_d    = byte_r;
    seq_d     = seq_r;
    txd_d     = txd_r;
    busy_d    = busy_r;
    done_d    = 1'b0;
    load_new  = 1'b0;
    load_pend = 1'b0;
    case (state_r)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (pend_r || pack_done) begin
          load_pend = pend_r;
          load_new  = ~pend_r;
          state_d   = START;
          cnt_d     = '0;
          byte_d    = 3'd0;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          txd_d   = cur_byte[0];
        end else begin
          cnt_d = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_r == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_nxt;
            txd_d = cur_byte[bit_nxt];
          end
        end else begin
          cnt_d = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (byte_r == 3'd5) begin
            state_d = DONE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_r + 3'd1;
            txd_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        seq_d = seq_r + 8'd1;
        if (pend_r) begin
          load_pend = 1'b1;
          state_d   = START;
          cnt_d     = '0;
          byte_d    = 3'd0;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (to_pend)
      pend_d = 1'b1;
    else if (load_pend)
      pend_d = 1'b0;
    else
      pend_d = pend_r;
  end

  // Control state register; a reset aborts any frame in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      byte_r  <= 3'd0;
      seq_r   <= 8'd0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pend_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_d;
      cnt_r   <= cnt_d;
      bit_r   <= bit_d;
      byte_r  <= byte_d;
      seq_r   <= seq_d;
      txd_r   <= txd_d;
      busy_r  <= busy_d;
      done_r  <= done_d;
      pend_r  <= pend_d;
      ovf_r   <= ovf_r | drop;
    end
  end

  // Frame payload and pending buffer; the checksum uses the sequence value
  // the frame will carry, which is already incremented when loaded in DONE.
  always_ff @(posedge sys_clk) begin
    if (load_new) begin
      fc_r   <= func_code;
      st_r   <= status;
      csum_r <= frame_sum(func_code, status, seq_d);
    end else if (load_pend) begin
      fc_r   <= pend_fc_r;
      st_r   <= pend_st_r;
      csum_r <= frame_sum(pend_fc_r, pend_st_r, seq_d);
    end
    if (to_pend) begin
      pend_fc_r <= func_code;
      pend_st_r <= status;
    end
  end

  assign uart_txd = txd_r;
  assign tx_busy  = busy_r;
  assign tx_done  = done_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_uart_ack_tx.sv
// Testbench for uart_ack_tx: a serial decoder on uart_txd is compared
// against a request-level model of frame scheduling (accept / park /
// drop), byte contents, byte start times and tx_done times.
module tb_uart_ack_tx;

  localparam int CLK_FREQ = 350;
  localparam int UART_BPS = 100;
  localparam int B        = CLK_FREQ / UART_BPS;
  localparam int FRAME    = 60 * B;

  logic       sys_clk   = 1'b0;
  logic       sys_rst   = 1'b1;
  logic       pack_done = 1'b0;
  logic [7:0] func_code = 8'h00;
  logic [7:0] status    = 8'h00;
  logic       uart_txd, tx_busy, tx_done, ovf;

  uart_ack_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .HDR0     (8'h55),
    .HDR1     (8'hAA)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pack_done (pack_done),
    .func_code (func_code),
    .status    (status),
    .uart_txd  (uart_txd),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .ovf       (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         t;
    logic [7:0] b;
  } exp_byte_t;

  exp_byte_t exp_q[$];
  int        done_q[$];
  int        cur_done;
  bit        pend_valid;
  int        pend_start;
  int        m_seq;
  bit        m_ovf;

  function automatic void model_reset();
    cur_done   = -1000;
    pend_valid = 1'b0;
    pend_start = 0;
    m_seq      = 0;
    m_ovf      = 1'b0;
    exp_q.delete();
    done_q.delete();
  endfunction

  // Queue the six bytes of a frame whose start bit begins at time s.
  function automatic void emit(input logic [7:0] fc, input logic [7:0] st, input int s);
    int        bytes[6];
    exp_byte_t e;
    bytes[0] = 'h55;
    bytes[1] = 'hAA;
    bytes[2] = fc;
    bytes[3] = st;
    bytes[4] = m_seq;
    bytes[5] = (bytes[0] + bytes[1] + bytes[2] + bytes[3] + bytes[4]) % 256;
    for (int i = 0; i < 6; i++) begin
      e.t = s + 10 * B * i;
      e.b = 8'(bytes[i]);
      exp_q.push_back(e);
    end
    done_q.push_back(s + FRAME);
    m_seq = (m_seq + 1) % 256;
  endfunction

  // Request sampled at clock edge r; the transmitter state it sees is the
  // one visible just before that edge (time r-1).
  function automatic void model_req(input int r, input logic [7:0] fc, input logic [7:0] st);
    if (pend_valid && r > pend_start) begin
      cur_done   = pend_start + FRAME;
      pend_valid = 1'b0;
    end
    if (pend_valid) begin
      m_ovf = 1'b1;
    end else if (r - 1 > cur_done) begin
      emit(fc, st, r);
      cur_done = r + FRAME;
    end else begin
      pend_start = (r - 1 < cur_done) ? cur_done + 1 : cur_done + 2;
      pend_valid = 1'b1;
      emit(fc, st, pend_start);
    end
  endfunction

  // ---------------- serial decoder / done monitor ----------------
  logic       mon_en = 1'b0;
  bit         mon_active = 1'b0;
  int         mon_t0, mon_k, mon_bitn;
  logic [9:0] mon_bits;
  bit         mon_cons;
  exp_byte_t  mon_e;

  always @(negedge sys_clk) begin
    if (!mon_en) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active) begin
        if (uart_txd === 1'b0) begin
          mon_active  = 1'b1;
          mon_t0      = cyc;
          mon_k       = 1;
          mon_bits    = '0;
          mon_cons    = 1'b1;
        end
      end else begin
        mon_bitn = mon_k / B;
        if (mon_k % B == 0)
          mon_bits[mon_bitn] = uart_txd;
        else if (uart_txd !== mon_bits[mon_bitn])
          mon_cons = 1'b0;
        mon_k++;
        if (mon_k == 10 * B) begin
          mon_active = 1'b0;
          check("bit_width", 32'(mon_cons), 32'd1);
          check("stop_bit", 32'(mon_bits[9]), 32'd1);
          if (exp_q.size() == 0) begin
            check("byte_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            mon_e = exp_q.pop_front();
            check("byte_value", 32'(mon_bits[8:1]), 32'(mon_e.b));
            check("byte_time", 32'(mon_t0), 32'(mon_e.t));
          end
        end
      end
      if (tx_done === 1'b1) begin
        if (done_q.size() == 0)
          check("done_unexpected", 32'(done_q.size()), 32'd1);
        else
          check("done_time", 32'(cyc), 32'(done_q.pop_front()));
        check("done_busy", 32'(tx_busy), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] fc, input logic [7:0] st, input bit now);
    if (!now) step();
    pack_done = 1'b1;
    func_code = fc;
    status    = st;
    model_req(cyc + 1, fc, st);
    step();
    pack_done = 1'b0;
    func_code = 8'($urandom);
    status    = 8'($urandom);
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    sys_rst = 1'b1;
    step();
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    model_reset();
    sys_rst = 1'b0;
    mon_en  = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((done_q.size() != 0 || tx_busy !== 1'b0) && n < limit) begin
      step();
      n++;
    end
    check("drain_done", 32'(done_q.size()), 32'd0);
    check("drain_bytes", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n;
    model_reset();
    repeat (3) step();
    do_reset();

    // Quiet line after reset.
    repeat (1000) begin
      step();
      check("idle", 32'({uart_txd, tx_busy, tx_done, ovf}), 32'b1000);
    end

    // Single frame and its latency.
    send(8'h01, 8'h5A, 1'b0);
    check("start_txd", 32'(uart_txd), 32'd0);
    check("start_busy", 32'(tx_busy), 32'd1);
    wait_idle(2 * FRAME);

    // Second frame carries seq 1.
    repeat (5) step();
    send(8'h02, 8'h0F, 1'b0);
    wait_idle(2 * FRAME);
    check("ovf_quiet", 32'(ovf), 32'(m_ovf));

    // Three requests 10 cycles apart: two back-to-back frames, one dropped.
    do_reset();
    send(8'h10, 8'h20, 1'b0);
    repeat (8) step();
    send(8'h11, 8'h21, 1'b0);
    repeat (8) step();
    send(8'h12, 8'h22, 1'b0);
    check("ovf_after_drop", 32'(ovf), 32'(m_ovf));
    wait_idle(3 * FRAME);
    check("ovf_sticky", 32'(ovf), 32'(m_ovf));

    // Reset in the middle of byte 3, then a fresh frame restarts at seq 0.
    send(8'h33, 8'h44, 1'b0);
    s = cyc;
    while (cyc < s + 30 * B + 1) step();
    do_reset();
    send(8'h77, 8'h88, 1'b0);
    wait_idle(2 * FRAME);

    // Random requests with random spacing.
    repeat (15) begin
      repeat ($urandom_range(1, 250)) step();
      send(8'($urandom), 8'($urandom), 1'b0);
    end
    wait_idle(4 * FRAME);
    check("rand_ovf", 32'(ovf), 32'(m_ovf));

    // Sequence wrap over 257 frames; some requests land in the DONE cycle.
    do_reset();
    send(8'($urandom), 8'($urandom), 1'b0);
    for (int i = 1; i < 257; i++) begin
      n = 0;
      while (tx_done !== 1'b1 && n < 2 * FRAME + 4) begin
        step();
        n++;
      end
      if (tx_done !== 1'b1) check("wrap_done_timeout", 32'(tx_done), 32'd1);
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle(3 * FRAME);
    check("wrap_ovf", 32'(ovf), 32'(m_ovf));
    check("wrap_seq", 32'(m_seq), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
